uart_bus_master: RTL and testbench
==================================

# uart_bus_master

Host-side bus sequencer upstream of the UART controller. Converts single-beat valid/ready register requests from a processor or test harness into the UART's asynchronous-style parallel bus cycle (`chip_sel_n`, `address`, `read_write`, 8-bit data). It guarantees the strobe shape the UART's posedge detectors require. It also optionally sequences interrupt acknowledges on `iack`. The tri-state `data_io` buffer lives at the top level; this block uses split `data_o`, `data_oe_o` and `data_i` signals.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 3: cycles `chip_sel_n_o` is held low per access. Legal range ≥ 2.
- `RECOVER_CYCLES`, default 1: cycles `chip_sel_n_o` is high after each access. Legal range ≥ 1.

Ports:
- `clk_i`  in  1  clock; the single clock for the block.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request ready; high only in IDLE with no IACK pending.
- `req_write_i`  in  1  1 = register write, 0 = register read.
- `req_addr_i`  in  3  UART register address.
- `req_wdata_i`  in  8  write data.
- `rsp_valid_o`  out  1  one-cycle completion pulse, issued for both reads and writes.
- `rsp_rdata_o`  out  8  read data; 0 for writes; held until the next completion.
- `chip_sel_n_o`  out  1  UART chip select, active low.
- `address_o`  out  3  UART address.
- `read_write_o`  out  1  1 = read, 0 = write.
- `data_o`  out  8  write data toward `data_io`.
- `data_oe_o`  out  1  tri-state enable for `data_io`.
- `data_i`  in  8  `data_io` as seen by the host.
- `ireq_n_i`  in  1  UART interrupt request, active low.
- `irq_o`  out  1  registered `!ireq_n_i`.
- `int_ack_i`  in  1  one-cycle request to acknowledge the interrupt.
- `iack_o`  out  1  UART interrupt acknowledge.

## Operation
- FSM states are IDLE, SETUP, ACCESS, RECOVER, IACK. A single counter of width `$clog2(max(ACCESS_CYCLES,RECOVER_CYCLES)+1)` times ACCESS, IACK and RECOVER.
- IDLE:
  - A request is accepted on `req_valid_i && req_ready_o`. Address, direction and write data are latched, then the FSM goes to SETUP.
  - A pending IACK has priority over a new request. While an IACK is pending, `req_ready_o` = 0.
- SETUP (1 cycle):
  - `address_o` and `read_write_o` are driven from the latched request while `chip_sel_n_o` = 1.
  - For a write, `data_o` and `data_oe_o` = 1 are also driven.
  - This cycle guarantees the address is stable before the strobe edge.
- ACCESS (`ACCESS_CYCLES` cycles):
  - `chip_sel_n_o` = 0; address, direction and write data are held.
  - For a read, `data_i` is captured into `rsp_rdata_o` on the last ACCESS cycle.
- RECOVER (`RECOVER_CYCLES` cycles):
  - `chip_sel_n_o` = 1, `data_oe_o` = 0, `read_write_o` = 1.
  - `rsp_valid_o` pulses in the first RECOVER cycle, but only if RECOVER was entered from ACCESS.
  - RECOVER then returns to IDLE.
- IACK (`ACCESS_CYCLES` cycles): `iack_o` = 1, then RECOVER. `iack_o` falls on entry to RECOVER.
- IACK pending flag:
  - Set by `int_ack_i` in any state.
  - Cleared on entry to IACK.
  - Multiple `int_ack_i` pulses while pending coalesce into one acknowledge.
- `irq_o` is `!ireq_n_i` delayed by one flop. It is independent of the FSM.
- Idle bus values: `chip_sel_n_o` = 1, `read_write_o` = 1, `address_o` = 0, `data_oe_o` = 0.
- The bus never drives `data_oe_o` = 1 while `read_write_o` = 1.

## Timing
- Reset values:
  - FSM = IDLE; counter = 0; pending = 0.
  - `req_ready_o` = 1 on the first cycle after reset.
  - `rsp_valid_o` = 0, `rsp_rdata_o` = 0.
  - `chip_sel_n_o` = 1, `address_o` = 0, `read_write_o` = 1.
  - `data_o` = 0, `data_oe_o` = 0.
  - `irq_o` = 0, `iack_o` = 0.
- Reset mid-operation: reset during SETUP, ACCESS, IACK or RECOVER forces the idle values at the next edge. The in-flight request gets no `rsp_valid_o`, and a pending IACK is dropped.
- Latency:
  - Acceptance at cycle 0; SETUP at cycle 1; ACCESS at cycles 2..1+A.
  - `rsp_valid_o` at cycle 2+A. With defaults this is cycle 5.
  - Next acceptance is possible at cycle 2+A+R. With defaults this is cycle 6.
- Each access produces exactly one falling edge of `chip_sel_n_o`.
- Back-to-back requests always see at least `RECOVER_CYCLES` of `chip_sel_n_o` high.
- An `int_ack_i` arriving during a bus access waits for that access's RECOVER. IACK starts on the cycle after the return to IDLE.

## Configuration
- Macro `UART_BUS_MASTER_IACK_EN`.
- Defined: IACK state, pending flag and the `irq_o` flop are present.
- Undefined:
  - `iack_o` is tied 0 and `irq_o` is tied 0.
  - `int_ack_i` is ignored.
  - The FSM has no IACK state, and `req_ready_o` depends only on IDLE.

## Structure
- `uart_pkg` gains:
  - `bus_master_state_e` (IDLE, SETUP, ACCESS, RECOVER, IACK).
  - `UART_RW_READ` = 1'b1 and `UART_RW_WRITE` = 1'b0.
- No sub-module. The counter and FSM stay inline in `uart_bus_master`.

## Test plan
- Write 0xA5 to address 3 (defaults) -> SETUP cycle drives `data_o` = 0xA5 with `data_oe_o` = 1; `chip_sel_n_o` is low for exactly 3 cycles with `read_write_o` = 0; `rsp_valid_o` at cycle 5 with `rsp_rdata_o` = 0.
- Read address 1 with `data_i` = 0x3C during ACCESS -> `rsp_rdata_o` = 0x3C at cycle 5; `data_oe_o` stays 0 throughout.
- Two back-to-back writes with `req_valid_i` held high -> second accepted at cycle 6; `chip_sel_n_o` high for ≥ 1 cycle between accesses; two `rsp_valid_o` pulses.
- `int_ack_i` pulse during a read's ACCESS, with macro defined -> read completes; `iack_o` high for 3 cycles afterwards; `req_ready_o` = 0 until IACK's RECOVER ends.
- `rst_i` asserted in the second ACCESS cycle -> next cycle `chip_sel_n_o` = 1, `req_ready_o` = 1, and no `rsp_valid_o` ever appears for that request.
- `ireq_n_i` driven 0 -> `irq_o` = 1 one cycle later. With the macro undefined, `irq_o` and `iack_o` stay 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: bus-master FSM states, read/write encoding and request payload.
package uart_pkg;

    localparam int unsigned UART_ADDR_W = 3;
    localparam int unsigned UART_DATA_W = 8;

    localparam logic UART_RW_READ  = 1'b1;
    localparam logic UART_RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        RECOVER = 3'd3,
        IACK    = 3'd4
    } bus_master_state_e;

    typedef struct packed {
        logic                   write;
        logic [UART_ADDR_W-1:0] addr;
        logic [UART_DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/uart_bus_master.sv
// Turns valid/ready register requests into the UART's chip-select bus cycle.
// Optional interrupt acknowledge sequencing under UART_BUS_MASTER_IACK_EN.
module uart_bus_master
    import uart_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES  = 3,
    parameter int unsigned RECOVER_CYCLES = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [UART_ADDR_W-1:0] req_addr_i,
    input  logic [UART_DATA_W-1:0] req_wdata_i,
    output logic                   rsp_valid_o,
    output logic [UART_DATA_W-1:0] rsp_rdata_o,
    output logic                   chip_sel_n_o,
    output logic [UART_ADDR_W-1:0] address_o,
    output logic                   read_write_o,
    output logic [UART_DATA_W-1:0] data_o,
    output logic                   data_oe_o,
    input  logic [UART_DATA_W-1:0] data_i,
    input  logic                   ireq_n_i,
    output logic                   irq_o,
    input  logic                   int_ack_i,
    output logic                   iack_o
);

    localparam int unsigned MAX_CYCLES = (ACCESS_CYCLES > RECOVER_CYCLES) ? ACCESS_CYCLES
                                                                          : RECOVER_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVER_CYCLES - 1);

    bus_master_state_e      state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    bus_req_t               req_q, req_d;
    logic                   pend_d;
    logic                   accept_c;

    logic                   cs_n_d, rw_d, oe_d, iack_d, ready_d, rsp_valid_d;
    logic [UART_ADDR_W-1:0] addr_d;
    logic [UART_DATA_W-1:0] data_d, rdata_d;

    assign accept_c = req_valid_i && req_ready_o;

    // State, counter and latched request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        req_d = req_q;
        if (accept_c) begin
            req_d.write = req_write_i;
            req_d.addr  = req_addr_i;
            req_d.wdata = req_wdata_i;
        end
    end

`ifdef UART_BUS_MASTER_IACK_EN
    logic pend_q;
    logic irq_q;

    // Acks coalesce while pending; the flag is consumed when IDLE launches IACK
    always_comb begin
        pend_d = pend_q;
        if (int_ack_i) begin
            pend_d = 1'b1;
        end
        if (state_q == IDLE && pend_q) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            irq_q  <= !ireq_n_i;
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_iack_c;

    assign pend_d        = 1'b0;
    assign irq_o         = 1'b0;
    assign unused_iack_c = int_ack_i ^ ireq_n_i;
`endif

    // Next state and cycle counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        case (state_q)
            IDLE: begin
`ifdef UART_BUS_MASTER_IACK_EN
                if (pend_q) begin
                    state_d = IACK;
                    cnt_d   = ACC_LOAD;
                end else
`endif
                if (accept_c) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = ACC_LOAD;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    cnt_d   = REC_LOAD;
                end
            end
`ifdef UART_BUS_MASTER_IACK_EN
            IACK: begin
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    cnt_d   = REC_LOAD;
                end
            end
`endif
            RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values for the state being entered; registered below
    always_comb begin
        cs_n_d      = 1'b1;
        addr_d      = '0;
        rw_d        = UART_RW_READ;
        data_d      = '0;
        oe_d        = 1'b0;
        iack_d      = 1'b0;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rdata_d     = rsp_rdata_o;
        case (state_d)
            IDLE: begin
                ready_d = !pend_d;
            end
            SETUP, ACCESS: begin
                cs_n_d = (state_d != ACCESS);
                addr_d = req_d.addr;
                if (req_d.write) begin
                    rw_d   = UART_RW_WRITE;
                    data_d = req_d.wdata;
                    oe_d   = 1'b1;
                end
            end
            RECOVER: begin
                addr_d = req_d.addr;
                if (state_q == ACCESS) begin
                    rsp_valid_d = 1'b1;
                    rdata_d     = req_d.write ? '0 : data_i;
                end
            end
`ifdef UART_BUS_MASTER_IACK_EN
            IACK: begin
                iack_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chip_sel_n_o <= 1'b1;
            address_o    <= '0;
            read_write_o <= UART_RW_READ;
            data_o       <= '0;
            data_oe_o    <= 1'b0;
            iack_o       <= 1'b0;
            req_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_rdata_o  <= '0;
        end else begin
            chip_sel_n_o <= cs_n_d;
            address_o    <= addr_d;
            read_write_o <= rw_d;
            data_o       <= data_d;
            data_oe_o    <= oe_d;
            iack_o       <= iack_d;
            req_ready_o  <= ready_d;
            rsp_valid_o  <= rsp_valid_d;
            rsp_rdata_o  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master with a register-file UART slave model.
// Expectations follow UART_BUS_MASTER_IACK_EN when it is defined.
module tb_uart_bus_master;
    import uart_pkg::*;

    localparam int A = 3;
    localparam int R = 1;
`ifdef UART_BUS_MASTER_IACK_EN
    localparam bit IACK_EN = 1'b1;
`else
    localparam bit IACK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       req_valid = 1'b0, req_write = 1'b0;
    logic [2:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready, rsp_valid, chip_sel_n, read_write, data_oe, irq, iack;
    logic [7:0] rsp_rdata, data_o, data_i;
    logic [2:0] address;
    logic       ireq_n = 1'b1, int_ack = 1'b0;

    always #5 clk = ~clk;

    uart_bus_master #(.ACCESS_CYCLES(A), .RECOVER_CYCLES(R)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .chip_sel_n_o(chip_sel_n), .address_o(address), .read_write_o(read_write),
        .data_o(data_o), .data_oe_o(data_oe), .data_i(data_i),
        .ireq_n_i(ireq_n), .irq_o(irq), .int_ack_i(int_ack), .iack_o(iack)
    );

    int   cyc = 0;
    logic rst_prev = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= rst_i;
    end

    // Slave register file: latches writes while selected, drives reads
    logic [7:0] init_mem [8];
    logic [7:0] slave_mem [8];
    logic [7:0] ref_mem [8];
    logic       preload = 1'b1;
    always @(posedge clk) begin
        if (preload) slave_mem <= init_mem;
        else if (!chip_sel_n && read_write == UART_RW_WRITE && data_oe)
            slave_mem[address] <= data_o;
    end
    assign data_i = (!chip_sel_n && read_write) ? slave_mem[address] : 8'hEE;

    typedef struct { logic [7:0] rdata; int due; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0, n_bad = 0, n_acc = 0, n_fall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive a request at a negedge; returns at the negedge of the SETUP cycle
    task automatic issue(input logic wr, input logic [2:0] addr, input logic [7:0] wd,
                         output int c0);
        int   n;
        exp_t e;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            c0 = -1;
            return;
        end
        c0 = cyc;
        n_acc++;
        e.due = c0 + 2 + A;
        if (wr) begin
            ref_mem[addr] = wd;
            e.rdata = 8'h00;
        end else begin
            e.rdata = ref_mem[addr];
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("idle_timeout", 32'(req_ready), 32'd1);
    endtask

    // Monitor: response scoreboard and strobe-shape checks
    int low_len = 0, high_len = 0;
    bit gap_valid = 1'b0;
    logic prev_cs = 1'b1;
    always @(negedge clk) begin
        if (rst_prev) begin
            low_len = 0; high_len = 0; gap_valid = 1'b0; prev_cs = 1'b1;
        end else begin
            check("oe_while_read", 32'(data_oe & read_write), 32'd0);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                    check("rsp_latency", 32'(cyc), 32'(mon_e.due));
                end
            end
            if (prev_cs && !chip_sel_n) begin
                n_fall++;
                if (gap_valid) check("cs_high_gap", 32'(high_len >= R), 32'd1);
                check("oe_matches_dir", 32'(data_oe), 32'(!read_write));
                low_len = 1;
            end else if (!chip_sel_n) begin
                low_len++;
            end else if (!prev_cs) begin
                check("cs_low_len", 32'(low_len), 32'(A));
                high_len = 1;
                gap_valid = 1'b1;
            end else begin
                high_len++;
            end
            prev_cs = chip_sel_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, c1, first_iack, iack_cnt, first_ready, n;
        for (int i = 0; i < 8; i++) begin
            init_mem[i] = 8'($urandom);
            ref_mem[i]  = init_mem[i];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        rst_i = 1'b0;
        @(negedge clk);

        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_cs_n", 32'(chip_sel_n), 32'd1);
        check("rst_address", 32'(address), 32'd0);
        check("rst_rw", 32'(read_write), 32'd1);
        check("rst_data_o", 32'(data_o), 32'd0);
        check("rst_oe", 32'(data_oe), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_iack", 32'(iack), 32'd0);

        // Write 0xA5 to address 3
        issue(1'b1, 3'd3, 8'hA5, c0);
        req_valid = 1'b0;
        check("setup_data", 32'(data_o), 32'hA5);
        check("setup_oe", 32'(data_oe), 32'd1);
        check("setup_cs_n", 32'(chip_sel_n), 32'd1);
        check("setup_addr", 32'(address), 32'd3);
        check("setup_rw", 32'(read_write), 32'd0);
        for (int k = 0; k < A; k++) begin
            @(negedge clk);
            check("wr_access_cs_n", 32'(chip_sel_n), 32'd0);
            check("wr_access_rw", 32'(read_write), 32'd0);
        end
        @(negedge clk);
        check("wr_recover_cs_n", 32'(chip_sel_n), 32'd1);

        // Read back 0x3C from address 1
        wait_idle();
        issue(1'b1, 3'd1, 8'h3C, c0);
        req_valid = 1'b0;
        wait_idle();
        issue(1'b0, 3'd1, 8'h00, c0);
        req_valid = 1'b0;
        for (int k = 1; k <= A + 2; k++) begin
            check("rd_oe_low", 32'(data_oe), 32'd0);
            @(negedge clk);
        end

        // Back-to-back writes with valid held
        wait_idle();
        issue(1'b1, 3'd2, 8'h5A, c0);
        issue(1'b1, 3'd5, 8'hC3, c1);
        req_valid = 1'b0;
        check("b2b_accept_gap", 32'(c1 - c0), 32'(2 + A + R));

        // Interrupt acknowledge requested twice during a read's ACCESS
        wait_idle();
        issue(1'b0, 3'd2, 8'h00, c0);
        req_valid = 1'b0;
        @(negedge clk); int_ack = 1'b1;
        @(negedge clk); int_ack = 1'b0;
        @(negedge clk); int_ack = 1'b1;
        @(negedge clk); int_ack = 1'b0;
        first_iack = -1; first_ready = -1; iack_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (iack) begin
                iack_cnt++;
                if (first_iack < 0) first_iack = cyc - c0;
            end
            if (req_ready && first_ready < 0) first_ready = cyc - c0;
            @(negedge clk);
        end
        check("iack_len", 32'(iack_cnt), IACK_EN ? 32'(A) : 32'd0);
        check("iack_start", 32'(first_iack), IACK_EN ? 32'(3 + A + R) : 32'hFFFF_FFFF);
        check("ready_after_iack", 32'(first_ready),
              IACK_EN ? 32'(3 + 2 * A + 2 * R) : 32'(2 + A + R));

        // irq follows !ireq_n one cycle later
        check("irq_idle", 32'(irq), 32'd0);
        ireq_n = 1'b0;
        @(negedge clk);
        check("irq_set", 32'(irq), 32'(IACK_EN));
        ireq_n = 1'b1;
        @(negedge clk);
        check("irq_clear", 32'(irq), 32'd0);

        // Reset in the second ACCESS cycle aborts the read silently
        wait_idle();
        issue(1'b0, 3'd4, 8'h00, c0);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check("abort_cs_n", 32'(chip_sel_n), 32'd1);
        check("abort_ready", 32'(req_ready), 32'd1);
        rst_i = 1'b0;
        void'(exp_q.pop_back());
        repeat (8) @(negedge clk);

        // Randomized traffic against the reference register file
        for (int t = 0; t < 40; t++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            if (gap > 0) req_valid = 1'b0;
            repeat (gap) @(negedge clk);
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), c0);
        end
        req_valid = 1'b0;

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        check("fall_count", 32'(n_fall), 32'(n_acc));
        check("iack_quiet", 32'(iack), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
